// File: rtl/lcd_seq_pkg.sv
// Shared opcodes, FSM state encoding and byte width
// for the LCD init sequencer and its delay timer.
package lcd_seq_pkg;

  localparam logic [1:0] OP_DATA  = 2'b00;
  localparam logic [1:0] OP_CMD   = 2'b01;
  localparam logic [1:0] OP_DELAY = 2'b10;
  localparam logic [1:0] OP_END   = 2'b11;

  localparam int BITS_PER_BYTE = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_LOAD,
    S_SHIFT,
    S_DELAY,
    S_DONE
  } state_e;

  function automatic logic is_write(
    input logic [1:0] op
  );
    return op[1] == 1'b0;
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter for delay instructions.
// Ports: clk, reset (sync, high), load_i/load_val_i
// load the count, en_i decrements, expire_o flags 1.
module lcd_delay_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Expiring on 1 (not 0) makes a load of N
  // occupy exactly N enabled cycles.
  assign expire_o = (cnt_q == W'(1));

endmodule

// File: rtl/lcd_init_sequencer.sv
// Runs a ROM program of write/delay/end words that
// feed a serial shift register driving an LCD panel.
// Ports: clk, reset, sclkPosEdge, start in; instrAddr
// and instrData form the ROM port; cs, dc, pcEn,
// parallelData drive the shifter; busy/done status.
module lcd_init_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int PROG_LEN   = 64,
  parameter int DELAY_UNIT = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclkPosEdge,
  input  logic              start,
  output logic [ADDR_W-1:0] instrAddr,
  input  logic [9:0]        instrData,
  output logic              cs,
  output logic              dc,
  output logic              pcEn,
  output logic [7:0]        parallelData,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W =
    $clog2(255 * DELAY_UNIT + 1);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(PROG_LEN - 1);
  localparam logic [2:0] BIT_LAST =
    3'(BITS_PER_BYTE - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cs_q, cs_d;
  logic              dc_q, dc_d;
  logic [7:0]        pd_q, pd_d;
  logic              done_q, done_d;
  logic [2:0]        bit_q, bit_d;

  logic              tmr_load;
  logic              tmr_exp;
  logic [CNT_W-1:0]  tmr_val;
  logic [1:0]        op;
  logic [7:0]        arg;

  assign op  = instrData[9:8];
  assign arg = instrData[7:0];

  assign tmr_val =
    CNT_W'(arg) * CNT_W'(DELAY_UNIT);

  lcd_delay_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .en_i      (state_q == S_DELAY),
    .expire_o  (tmr_exp)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cs_q    <= 1'b1;
      dc_q    <= 1'b1;
      pd_q    <= '0;
      done_q  <= 1'b0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cs_q    <= cs_d;
      dc_q    <= dc_d;
      pd_q    <= pd_d;
      done_q  <= done_d;
      bit_q   <= bit_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cs_d     = cs_q;
    dc_d     = dc_q;
    pd_d     = pd_q;
    bit_d    = bit_q;
    tmr_load = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          is_write(op): begin
            pd_d    = arg;
            dc_d    = ~op[0];
            cs_d    = 1'b0;
            state_d = S_LOAD;
          end
          (op == OP_DELAY): begin
            cs_d = 1'b1;
            if (arg == 8'd0) begin
              if (addr_q == LAST) begin
                state_d = S_DONE;
              end else begin
                addr_d  = addr_q + 1'b1;
                state_d = S_FETCH;
              end
            end else begin
              tmr_load = 1'b1;
              state_d  = S_DELAY;
            end
          end
          (op == OP_END): begin
            cs_d    = 1'b1;
            state_d = S_DONE;
          end
          default: ;
        endcase
      end
      S_LOAD: begin
        if (sclkPosEdge) begin
          bit_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (sclkPosEdge) begin
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            if (addr_q == LAST) begin
              state_d = S_DONE;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = S_FETCH;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_DELAY: begin
        if (tmr_exp) begin
          if (addr_q == LAST) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        if (!start) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Any route into DONE releases the panel.
    if (state_d == S_DONE) begin
      cs_d = 1'b1;
    end
    done_d = (state_d == S_DONE) &&
             (state_q != S_DONE);
  end

  assign instrAddr    = addr_q;
  assign cs           = cs_q;
  assign dc           = dc_q;
  assign parallelData = pd_q;
  assign done         = done_q;
  assign pcEn  = (state_q == S_LOAD) && sclkPosEdge;
  assign busy  = (state_q != S_IDLE) &&
                 (state_q != S_DONE);

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Directed bench for lcd_init_sequencer: writes,
// delays, program-length stop, reset abort, start.
module tb_lcd_init_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, sclkPosEdge, start, start2;
  logic [5:0] instrAddr, instrAddr2;
  logic [9:0] instrData, instrData2;
  logic       cs, dc, pcEn, busy, done;
  logic       cs2, dc2, pcEn2, busy2, done2;
  logic [7:0] parallelData, parallelData2;

  logic [9:0] rom  [64];
  logic [9:0] rom2 [64];

  always @(posedge clk) begin
    instrData  <= rom[instrAddr];
    instrData2 <= rom2[instrAddr2];
  end

  lcd_init_sequencer #(
    .ADDR_W(6), .PROG_LEN(64), .DELAY_UNIT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .sclkPosEdge(sclkPosEdge), .start(start),
    .instrAddr(instrAddr), .instrData(instrData),
    .cs(cs), .dc(dc), .pcEn(pcEn),
    .parallelData(parallelData),
    .busy(busy), .done(done)
  );

  lcd_init_sequencer #(
    .ADDR_W(6), .PROG_LEN(2), .DELAY_UNIT(4)
  ) dut2 (
    .clk(clk), .reset(reset),
    .sclkPosEdge(sclkPosEdge), .start(start2),
    .instrAddr(instrAddr2), .instrData(instrData2),
    .cs(cs2), .dc(dc2), .pcEn(pcEn2),
    .parallelData(parallelData2),
    .busy(busy2), .done(done2)
  );

  int checks = 0;
  int failures = 0;
  int ph = 0;
  logic sclk_en = 1'b1;

  int cyc_n, pc_cnt, done_cnt, busy_cnt;
  int cs_fall, cs_rise, first_low;
  logic [7:0] pd_log [4];
  logic       dc_log [4];
  logic       cs_log [4];
  logic       prev_cs;
  int pc2, done2_cnt, max_addr2;
  logic [7:0] pd2_log [4];

  task automatic clear_mon();
    cyc_n = 0; pc_cnt = 0; done_cnt = 0;
    busy_cnt = 0; cs_fall = 0; cs_rise = 0;
    first_low = 0; prev_cs = cs;
    pc2 = 0; done2_cnt = 0; max_addr2 = 0;
    for (int i = 0; i < 4; i++) begin
      pd_log[i] = '0; dc_log[i] = 1'b0;
      cs_log[i] = 1'b1; pd2_log[i] = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ph++;
    sclkPosEdge = sclk_en && (ph % 4 == 0);
    #1;
    cyc_n++;
    if (pcEn) begin
      if (pc_cnt < 4) begin
        pd_log[pc_cnt] = parallelData;
        dc_log[pc_cnt] = dc;
        cs_log[pc_cnt] = cs;
      end
      pc_cnt++;
    end
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    if (!cs && first_low == 0) first_low = cyc_n;
    if (prev_cs && !cs) cs_fall++;
    if (!prev_cs && cs) cs_rise++;
    prev_cs = cs;
    if (pcEn2) begin
      if (pc2 < 4) pd2_log[pc2] = parallelData2;
      pc2++;
    end
    if (done2) done2_cnt++;
    if (int'(instrAddr2) > max_addr2)
      max_addr2 = int'(instrAddr2);
  endtask

  task automatic run_done(
    input int budget, output bit ok
  );
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic load3(
    input logic [9:0] a, b, c
  );
    for (int i = 0; i < 64; i++) rom[i] = 10'h300;
    rom[0] = a; rom[1] = b; rom[2] = c;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    sclkPosEdge = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (instrAddr !== 6'd0) begin
      failures++;
      $display("FAIL reset_addr got=%0d exp=0",
               instrAddr);
    end
    checks++;
    if (cs !== 1'b1 || dc !== 1'b1) begin
      failures++;
      $display("FAIL reset_cs_dc got=%b%b exp=11",
               cs, dc);
    end
    checks++;
    if (pcEn !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b%b%b exp=000",
               pcEn, busy, done);
    end
    checks++;
    if (parallelData !== 8'h00) begin
      failures++;
      $display("FAIL reset_pd got=%h exp=00",
               parallelData);
    end
    reset = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || busy2 !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_start got=%b%b exp=00",
               busy, busy2);
    end
  endtask

  task automatic test_write_seq();
    bit ok;
    load3(10'h1AE, 10'h055, 10'h300);
    clear_mon();
    start = 1'b1; step(); start = 1'b0;
    run_done(400, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wr_timeout got=0 exp=done");
    end
    checks++;
    if (pc_cnt !== 2) begin
      failures++;
      $display("FAIL wr_pcen got=%0d exp=2", pc_cnt);
    end
    checks++;
    if (pd_log[0] !== 8'hAE || dc_log[0] !== 1'b0)
    begin
      failures++;
      $display("FAIL wr_byte0 got=%h/%b exp=AE/0",
               pd_log[0], dc_log[0]);
    end
    checks++;
    if (pd_log[1] !== 8'h55 || dc_log[1] !== 1'b1)
    begin
      failures++;
      $display("FAIL wr_byte1 got=%h/%b exp=55/1",
               pd_log[1], dc_log[1]);
    end
    checks++;
    if (first_low !== 3 || cs_log[0] !== 1'b0) begin
      failures++;
      $display("FAIL wr_cs_low got=%0d/%b exp=3/0",
               first_low, cs_log[0]);
    end
    checks++;
    if (cs_fall !== 1 || cs_rise !== 1) begin
      failures++;
      $display("FAIL wr_cs_edges got=%0d/%0d exp=1/1",
               cs_fall, cs_rise);
    end
    step(); step();
    checks++;
    if (done_cnt !== 1 || cs !== 1'b1 ||
        busy !== 1'b0) begin
      failures++;
      $display("FAIL wr_end got=%0d/%b/%b exp=1/1/0",
               done_cnt, cs, busy);
    end
  endtask

  task automatic test_delay();
    bit ok;
    load3(10'h203, 10'h300, 10'h300);
    clear_mon();
    start = 1'b1; step(); start = 1'b0;
    run_done(200, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL dly_timeout got=0 exp=done");
    end
    // FETCH+DECODE, 12 DELAY, FETCH+DECODE
    checks++;
    if (busy_cnt !== 16) begin
      failures++;
      $display("FAIL dly_len got=%0d exp=16",
               busy_cnt);
    end
    checks++;
    if (pc_cnt !== 0 || cs_fall !== 0) begin
      failures++;
      $display("FAIL dly_quiet got=%0d/%0d exp=0/0",
               pc_cnt, cs_fall);
    end
    step(); step();
    checks++;
    if (done_cnt !== 1) begin
      failures++;
      $display("FAIL dly_done got=%0d exp=1",
               done_cnt);
    end
  endtask

  task automatic test_zero_delay();
    bit ok;
    load3(10'h200, 10'h0FF, 10'h300);
    clear_mon();
    start = 1'b1; step(); start = 1'b0;
    run_done(300, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL zd_timeout got=0 exp=done");
    end
    checks++;
    if (first_low !== 5) begin
      failures++;
      $display("FAIL zd_skip got=%0d exp=5",
               first_low);
    end
    checks++;
    if (pc_cnt !== 1 || pd_log[0] !== 8'hFF ||
        dc_log[0] !== 1'b1) begin
      failures++;
      $display("FAIL zd_byte got=%0d/%h/%b exp=1/FF/1",
               pc_cnt, pd_log[0], dc_log[0]);
    end
    step(); step();
  endtask

  task automatic test_prog_len();
    bit ok;
    for (int i = 0; i < 64; i++) rom2[i] = 10'h300;
    rom2[0] = 10'h001; rom2[1] = 10'h002;
    clear_mon();
    start2 = 1'b1; step(); start2 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (done2) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL pl_timeout got=0 exp=done");
    end
    checks++;
    if (pc2 !== 2 || pd2_log[0] !== 8'h01 ||
        pd2_log[1] !== 8'h02) begin
      failures++;
      $display("FAIL pl_bytes got=%0d/%h/%h exp=2/01/02",
               pc2, pd2_log[0], pd2_log[1]);
    end
    step(); step();
    checks++;
    if (instrAddr2 !== 6'd1 || max_addr2 !== 1) begin
      failures++;
      $display("FAIL pl_addr got=%0d/%0d exp=1/1",
               instrAddr2, max_addr2);
    end
    checks++;
    if (done2_cnt !== 1 || cs2 !== 1'b1) begin
      failures++;
      $display("FAIL pl_done got=%0d/%b exp=1/1",
               done2_cnt, cs2);
    end
  endtask

  task automatic test_reset_mid_shift();
    bit ok;
    int edges;
    load3(10'h1AE, 10'h055, 10'h300);
    clear_mon();
    edges = 0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (pc_cnt >= 1 && sclkPosEdge && !pcEn)
        edges++;
      if (edges == 4) break;
    end
    checks++;
    if (edges !== 4 || cs !== 1'b0) begin
      failures++;
      $display("FAIL rs_reach got=%0d/%b exp=4/0",
               edges, cs);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (cs !== 1'b1 || busy !== 1'b0 ||
        pcEn !== 1'b0) begin
      failures++;
      $display("FAIL rs_abort got=%b%b%b exp=100",
               cs, busy, pcEn);
    end
    checks++;
    if (instrAddr !== 6'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL rs_state got=%0d/%b exp=0/0",
               instrAddr, done);
    end
    step();
    clear_mon();
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if (busy !== 1'b1 || instrAddr !== 6'd0) begin
      failures++;
      $display("FAIL rs_restart got=%b/%0d exp=1/0",
               busy, instrAddr);
    end
    run_done(400, ok);
    checks++;
    if (!ok || pc_cnt !== 2 ||
        pd_log[0] !== 8'hAE) begin
      failures++;
      $display("FAIL rs_rerun got=%b/%0d/%h exp=1/2/AE",
               ok, pc_cnt, pd_log[0]);
    end
    step(); step();
  endtask

  task automatic test_start_held();
    bit ok;
    int busy_after;
    load3(10'h1AE, 10'h055, 10'h300);
    clear_mon();
    start = 1'b1;
    run_done(400, ok);
    busy_after = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (busy) busy_after++;
    end
    checks++;
    if (!ok || done_cnt !== 1 || pc_cnt !== 2) begin
      failures++;
      $display("FAIL sh_single got=%b/%0d/%0d exp=1/1/2",
               ok, done_cnt, pc_cnt);
    end
    checks++;
    if (busy_after !== 0 || cs !== 1'b1) begin
      failures++;
      $display("FAIL sh_hold got=%0d/%b exp=0/1",
               busy_after, cs);
    end
    start = 1'b0; step();
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if (busy !== 1'b1 || instrAddr !== 6'd0) begin
      failures++;
      $display("FAIL sh_rearm got=%b/%0d exp=1/0",
               busy, instrAddr);
    end
    run_done(400, ok);
    checks++;
    if (!ok || done_cnt !== 2) begin
      failures++;
      $display("FAIL sh_second got=%b/%0d exp=1/2",
               ok, done_cnt);
    end
    step(); step();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      rom[i] = 10'h300;
      rom2[i] = 10'h300;
    end
    test_reset();
    test_write_seq();
    test_delay();
    test_zero_delay();
    test_prog_len();
    test_reset_mid_shift();
    test_start_held();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_init_sequencer.md
LCD_INIT_SEQUENCER -- requirements
Module: lcd_init_sequencer

Interface
REQ-001 Parameter ADDR_W, default 6: instruction address width.
REQ-002 Parameter PROG_LEN, default 64: number of program words, 1..2**ADDR_W.
REQ-003 Parameter DELAY_UNIT, default 1000: clk cycles per delay tick.
REQ-004 clk  in  1  single system clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 sclkPosEdge  in  1  one-clk pulse per serial-clock rising edge, from serialClock.
REQ-007 start  in  1  level; sampled only in IDLE; begins program run.
REQ-008 instrAddr  out  ADDR_W  program ROM address.
REQ-009 instrData  in  10  ROM word; valid exactly 1 clk after instrAddr changes; [9:8] opcode, [7:0] operand.
REQ-010 cs  out  1  panel chip select, active-low.
REQ-011 dc  out  1  1 = data byte, 0 = command byte.
REQ-012 pcEn  out  1  one-clk parallel-load strobe to the shift register.
REQ-013 parallelData  out  8  byte presented to the shift register; registered.
REQ-014 busy  out  1  high in every state except IDLE and DONE.
REQ-015 done  out  1  one-clk pulse on entry to DONE.

Function
REQ-016 Opcodes SHALL be: 00 write data, 01 write command, 10 delay, 11 end.
REQ-017 States SHALL be IDLE, FETCH, DECODE, LOAD, SHIFT, DELAY, DONE.
REQ-018 IDLE: start=1 -> FETCH with instrAddr=0; start=0 -> stay.
REQ-019 FETCH: one clk, holds instrAddr -> DECODE; DECODE samples instrData.
REQ-020 DECODE 00/01: latch operand to parallelData, dc=~opcode[0], cs=0 -> LOAD.
REQ-021 LOAD: wait for sclkPosEdge; on that cycle pcEn=1 for exactly one clk -> SHIFT.
REQ-022 SHIFT: count 8 further sclkPosEdge pulses (3-bit counter); on the 8th -> next instruction.
REQ-023 DECODE 10: cs=1, load delay count operand*DELAY_UNIT -> DELAY; operand 0 -> next instruction directly.
REQ-024 DELAY: decrement every clk; on reaching 1 -> next instruction; total DELAY state time = operand*DELAY_UNIT clks.
REQ-025 DECODE 11: cs=1 -> DONE.
REQ-026 Next instruction: instrAddr+1 -> FETCH; if instrAddr = PROG_LEN-1, -> DONE instead (no wrap).
REQ-027 cs SHALL stay low across consecutive write instructions; rises only on delay, end, DONE, reset.
REQ-028 DONE: done pulses on entry; hold cs=1, pcEn=0; -> IDLE when start=0.
REQ-029 start while busy SHALL be ignored; no restart mid-program.
REQ-030 sclkPosEdge arriving in DECODE is not counted; LOAD waits for the next one.
REQ-031 Delay counter width SHALL be ceil(log2(255*DELAY_UNIT+1)) bits; no overflow.

Reset
REQ-032 reset SHALL force IDLE, instrAddr=0, cs=1, dc=1, pcEn=0, parallelData=0, busy=0, done=0, counters=0.
REQ-033 reset mid-SHIFT or mid-DELAY SHALL abort immediately; cs=1 on the next clk.

Structure
REQ-034 Opcode constants, state encodings and the bit-count constant 8 SHALL live in a shared package lcd_seq_pkg.
REQ-035 Delay counting SHALL be a sub-module lcd_delay_timer (load, count, expire).

Verification
REQ-036 ROM {01_AE, 00_55, 11_00}, start pulse -> cs low from first LOAD; pcEn pulses twice; dc=0 then 1; parallelData 0xAE then 0x55; done once; cs=1 at end.
REQ-037 ROM {10_03, 11_00}, DELAY_UNIT=4 -> DELAY state lasts exactly 12 clks, cs=1 throughout, no pcEn.
REQ-038 ROM {10_00, 00_FF, 11_00} -> zero delay skipped, next FETCH directly follows DECODE; 0xFF loaded.
REQ-039 PROG_LEN=2, ROM {00_01, 00_02} without end -> both bytes sent, instrAddr stops at 1, done pulses.
REQ-040 Assert reset during 4th SHIFT edge -> next clk: IDLE, cs=1, busy=0, pcEn=0; start restarts at address 0.
REQ-041 start held high through whole run -> single run only; stays in DONE until start drops.
